// File: rtl/pieo_datatypes.sv
// pieo_datatypes: op encoding and empty-entry defaults shared by the PIEO sublist
package pieo_datatypes;
  typedef enum logic [1:0] {
    OP_INSERT  = 2'b00,
    OP_EXTRACT = 2'b01,
    OP_FLUSH   = 2'b10,
    OP_RSVD    = 2'b11
  } pieo_op_t;
  localparam int PHASE_W = 4;
  localparam int DEF_NULL_BUCKET = 17;
  localparam logic EMPTY_RANK_BIT = 1'b1;
  localparam logic EMPTY_PAYLOAD_BIT = 1'b0;
endpackage

// File: rtl/pieo_first_set.sv
// pieo_first_set: N-wide priority encoder, lowest set bit wins
module pieo_first_set #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) idx_o = vec_i[i] ? IW'(i) : idx_o;
  end
  assign found_o = |vec_i;
endmodule

// File: rtl/pieo_param_sublist.sv
// pieo_param_sublist: rank-sorted PIEO sublist with insert and extract-first-eligible.
// PIEO_SUBLIST_FLUSH_EN adds op 10, removal of the first entry whose payload id matches.
module pieo_param_sublist
  import pieo_datatypes::*;
#(
  parameter int NUM_ELEM    = 8,
  parameter int RANK_W      = 4,
  parameter int BUCKET_W    = 7,
  parameter int TIME_W      = 18,
  parameter int NULL_BUCKET = DEF_NULL_BUCKET,
  parameter int PAYLOAD_W   = 10,
  localparam int NW = $clog2(NUM_ELEM + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [RANK_W-1:0]    cmd_rank,
  input  logic [BUCKET_W-1:0]  cmd_bucket,
  input  logic [PAYLOAD_W-1:0] cmd_payload,
  input  logic [TIME_W-1:0]    curr_time_in,
  output logic                 resp_valid,
  output logic                 resp_ok,
  output logic [RANK_W-1:0]    resp_rank,
  output logic [BUCKET_W-1:0]  resp_bucket,
  output logic [PAYLOAD_W-1:0] resp_payload,
  output logic [NW-1:0]        num,
  output logic                 full,
  output logic                 empty,
  output logic [RANK_W-1:0]    smallest_rank,
  output logic [TIME_W-1:0]    bucket_bitmap
);
  localparam int IW = $clog2(NUM_ELEM);
  localparam logic [BUCKET_W-1:0] NB = BUCKET_W'(NULL_BUCKET);
  typedef enum logic [1:0] {IDLE, CMP, SHIFT} state_t;
  state_t state_q, state_d;
  pieo_op_t op_q;
  logic [RANK_W-1:0] in_rank_q;
  logic [BUCKET_W-1:0] in_bucket_q;
  logic [PAYLOAD_W-1:0] in_payload_q;
  logic [TIME_W-1:0] time_q;
  logic [NUM_ELEM-1:0][RANK_W-1:0] rank_q, rank_d;
  logic [NUM_ELEM-1:0][BUCKET_W-1:0] bucket_q, bucket_d;
  logic [NUM_ELEM-1:0][PAYLOAD_W-1:0] payload_q, payload_d;
  logic [NW-1:0] num_q, num_d, ins_pos;
  logic [NUM_ELEM-1:0] valid, gt, sel, gt_q, sel_q;
  logic [IW-1:0] gt_idx, sel_idx;
  logic gt_found, sel_found, is_ext, do_ins, do_ext;
  pieo_first_set #(.N(NUM_ELEM)) u_ins (.vec_i(gt_q), .idx_o(gt_idx), .found_o(gt_found));
  pieo_first_set #(.N(NUM_ELEM)) u_sel (.vec_i(sel_q), .idx_o(sel_idx), .found_o(sel_found));
  assign cmd_ready = state_q == IDLE;
  assign state_d = state_q == IDLE ? (cmd_valid ? CMP : IDLE) : state_q == CMP ? SHIFT : IDLE;
`ifdef PIEO_SUBLIST_FLUSH_EN
  assign is_ext = op_q == OP_EXTRACT || op_q == OP_FLUSH;
`else
  assign is_ext = op_q == OP_EXTRACT;
`endif
  assign do_ins = state_q == SHIFT && op_q == OP_INSERT && !full;
  assign do_ext = state_q == SHIFT && is_ext && sel_found;
  assign ins_pos = gt_found ? NW'(gt_idx) : num_q;
  assign resp_valid = state_q == SHIFT && !rst;
  assign resp_ok = do_ins || do_ext;
  assign resp_rank = do_ext ? rank_q[sel_idx] : '0;
  assign resp_bucket = do_ext ? bucket_q[sel_idx] : '0;
  assign resp_payload = do_ext ? payload_q[sel_idx] : '0;
  assign num = num_q;
  assign full = num_q == NW'(NUM_ELEM);
  assign empty = num_q == '0;
  assign smallest_rank = rank_q[0];
  // Shifting a one-hot by a bucket >= TIME_W yields zero, so such buckets never match.
  always_comb begin
    bucket_bitmap = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      valid[i] = NW'(i) < num_q;
      gt[i] = valid[i] && rank_q[i] > in_rank_q;
      sel[i] = valid[i] && bucket_q[i] != NB && |(time_q & (TIME_W'(1) << bucket_q[i]));
`ifdef PIEO_SUBLIST_FLUSH_EN
      if (op_q == OP_FLUSH) sel[i] = valid[i] && payload_q[i][PHASE_W-1:0] == in_payload_q[PHASE_W-1:0];
`endif
      bucket_bitmap = valid[i] ? bucket_bitmap | (TIME_W'(1) << bucket_q[i]) : bucket_bitmap;
    end
  end
  always_comb begin
    rank_d = rank_q;
    bucket_d = bucket_q;
    payload_d = payload_q;
    num_d = num_q;
    if (do_ins) begin
      for (int i = 1; i < NUM_ELEM; i++) begin
        if (NW'(i) > ins_pos) begin
          rank_d[i] = rank_q[i-1];
          bucket_d[i] = bucket_q[i-1];
          payload_d[i] = payload_q[i-1];
        end
      end
      for (int i = 0; i < NUM_ELEM; i++) begin
        if (NW'(i) == ins_pos) begin
          rank_d[i] = in_rank_q;
          bucket_d[i] = in_bucket_q;
          payload_d[i] = in_payload_q;
        end
      end
      num_d = num_q + NW'(1);
    end else if (do_ext) begin
      for (int i = 0; i < NUM_ELEM - 1; i++) begin
        if (IW'(i) >= sel_idx) begin
          rank_d[i] = rank_q[i+1];
          bucket_d[i] = bucket_q[i+1];
          payload_d[i] = payload_q[i+1];
        end
      end
      rank_d[NUM_ELEM-1] = {RANK_W{EMPTY_RANK_BIT}};
      bucket_d[NUM_ELEM-1] = NB;
      payload_d[NUM_ELEM-1] = {PAYLOAD_W{EMPTY_PAYLOAD_BIT}};
      num_d = num_q - NW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q <= '0;
      rank_q <= {NUM_ELEM{{RANK_W{EMPTY_RANK_BIT}}}};
      bucket_q <= {NUM_ELEM{NB}};
      payload_q <= {NUM_ELEM{{PAYLOAD_W{EMPTY_PAYLOAD_BIT}}}};
      gt_q <= '0;
      sel_q <= '0;
    end else begin
      num_q <= num_d;
      rank_q <= rank_d;
      bucket_q <= bucket_d;
      payload_q <= payload_d;
      if (state_q == CMP) begin
        gt_q <= gt;
        sel_q <= sel;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= OP_RSVD;
      in_rank_q <= '0;
      in_bucket_q <= '0;
      in_payload_q <= '0;
      time_q <= '0;
    end else if (cmd_valid && cmd_ready) begin
      op_q <= pieo_op_t'(cmd_op);
      in_rank_q <= cmd_rank;
      in_bucket_q <= cmd_bucket;
      in_payload_q <= cmd_payload;
      time_q <= curr_time_in & ~(TIME_W'(1) << NULL_BUCKET);
    end
  end
endmodule

// File: tb/tb_pieo_param_sublist.sv
// tb_pieo_param_sublist: directed scoreboard bench for pieo_param_sublist
module tb_pieo_param_sublist;
  logic clk = 0;
  logic rst = 1;
  logic cmd_valid = 0;
  logic cmd_ready;
  logic [1:0] cmd_op = 0;
  logic [3:0] cmd_rank = 0;
  logic [6:0] cmd_bucket = 0;
  logic [9:0] cmd_payload = 0;
  logic [17:0] curr_time_in = 0;
  logic resp_valid, resp_ok, full, empty;
  logic [3:0] resp_rank, smallest_rank;
  logic [6:0] resp_bucket;
  logic [9:0] resp_payload;
  logic [3:0] num;
  logic [17:0] bucket_bitmap;
  int checks = 0;
  int fails = 0;
  logic [21:0] exp_q[$];
  localparam logic [17:0] ALL = 18'h3FFFF;
  pieo_param_sublist dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rank(cmd_rank), .cmd_bucket(cmd_bucket), .cmd_payload(cmd_payload),
    .curr_time_in(curr_time_in), .resp_valid(resp_valid), .resp_ok(resp_ok),
    .resp_rank(resp_rank), .resp_bucket(resp_bucket), .resp_payload(resp_payload),
    .num(num), .full(full), .empty(empty), .smallest_rank(smallest_rank),
    .bucket_bitmap(bucket_bitmap)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (resp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected got=%h", {resp_ok, resp_rank, resp_bucket, resp_payload});
      end else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        if ({resp_ok, resp_rank, resp_bucket, resp_payload} !== e) begin
          fails++;
          $display("FAIL resp got ok=%0b r=%0d b=%0d p=%h expected ok=%0b r=%0d b=%0d p=%h",
                   resp_ok, resp_rank, resp_bucket, resp_payload, e[21], e[20:17], e[16:10], e[9:0]);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask
  task automatic issue(input logic [1:0] op, input logic [3:0] r, input logic [6:0] b,
                       input logic [9:0] p, input logic [17:0] t, input logic eok,
                       input logic [3:0] er, input logic [6:0] eb, input logic [9:0] ep);
    wait_ready();
    exp_q.push_back({eok, er, eb, ep});
    cmd_valid = 1;
    cmd_op = op;
    cmd_rank = r;
    cmd_bucket = b;
    cmd_payload = p;
    curr_time_in = t;
    @(negedge clk);
    cmd_valid = 0;
    cmd_op = 2'b11;
    cmd_rank = 0;
    cmd_bucket = 0;
    cmd_payload = 0;
    curr_time_in = 0;
    wait_ready();
    chk("resp_seen", exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic ins(input logic [3:0] r, input logic [6:0] b, input logic [9:0] p, input logic eok);
    issue(2'b00, r, b, p, 0, eok, 0, 0, 0);
  endtask
  task automatic ext(input logic [17:0] t, input logic eok, input logic [3:0] er,
                     input logic [6:0] eb, input logic [9:0] ep);
    issue(2'b01, 0, 0, 0, t, eok, er, eb, ep);
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_ok", resp_ok, 0);
    chk("rst_resp_fields", {resp_rank, resp_bucket, resp_payload}, 0);
    chk("rst_num", num, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_smallest", smallest_rank, 4'hF);
    chk("rst_bitmap", bucket_bitmap, 0);
    ins(5, 1, 10'h011, 1);
    ins(2, 2, 10'h022, 1);
    ins(7, 3, 10'h033, 1);
    chk("ord_num", num, 3);
    chk("ord_bitmap", bucket_bitmap, 18'h0000E);
    chk("ord_smallest", smallest_rank, 2);
    chk("ord_empty", empty, 0);
    ext(ALL, 1, 2, 2, 10'h022);
    ext(ALL, 1, 5, 1, 10'h011);
    ext(ALL, 1, 7, 3, 10'h033);
    chk("drain_num", num, 0);
    chk("drain_smallest", smallest_rank, 4'hF);
    chk("drain_bitmap", bucket_bitmap, 0);
    ins(4, 1, 10'h00A, 1);
    ins(4, 1, 10'h00B, 1);
    ext(ALL, 1, 4, 1, 10'h00A);
    ext(ALL, 1, 4, 1, 10'h00B);
    ins(1, 3, 10'h001, 1);
    ins(2, 4, 10'h002, 1);
    ext(18'h00010, 1, 2, 4, 10'h002);
    chk("elig_num", num, 1);
    ext(18'h00010, 0, 0, 0, 0);
    chk("inelig_num", num, 1);
    ext(18'h00008, 1, 1, 3, 10'h001);
    ins(3, 17, 10'h017, 1);
    ins(1, 20, 10'h020, 1);
    ext(ALL, 0, 0, 0, 0);
    chk("null_num", num, 2);
    chk("null_bitmap", bucket_bitmap, 18'h20000);
    chk("null_smallest", smallest_rank, 1);
    wait_ready();
    cmd_valid = 1;
    cmd_op = 2'b00;
    cmd_rank = 5;
    cmd_bucket = 5;
    cmd_payload = 10'h055;
    @(posedge clk);
    #1 cmd_valid = 0;
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_shift_no_resp", resp_valid, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_shift_num", num, 0);
    chk("rst_shift_ready", cmd_ready, 1);
    chk("rst_shift_bitmap", bucket_bitmap, 0);
    for (int i = 7; i >= 0; i--) ins(4'(i), 7'(i), 10'(i), 1);
    chk("fill_full", full, 1);
    chk("fill_num", num, 8);
    chk("fill_bitmap", bucket_bitmap, 18'h000FF);
    chk("fill_smallest", smallest_rank, 0);
    ins(9, 1, 10'h099, 0);
    chk("over_full", full, 1);
    chk("over_num", num, 8);
    ext(18'h00020, 1, 5, 5, 10'h005);
    chk("mid_num", num, 7);
    chk("mid_full", full, 0);
    chk("mid_bitmap", bucket_bitmap, 18'h000DF);
    ext(18'h00080, 1, 7, 7, 10'h007);
    chk("last_bitmap", bucket_bitmap, 18'h0005F);
    issue(2'b11, 1, 1, 1, ALL, 0, 0, 0, 0);
    chk("rsvd_num", num, 6);
    do_reset();
    ext(ALL, 0, 0, 0, 0);
    chk("empty_ext_num", num, 0);
    chk("empty_ext_empty", empty, 1);
    ins(1, 1, 10'h001, 1);
    ins(2, 2, 10'h013, 1);
    ins(3, 3, 10'h023, 1);
`ifdef PIEO_SUBLIST_FLUSH_EN
    issue(2'b10, 0, 0, 10'h003, 0, 1, 2, 2, 10'h013);
    chk("flush_num", num, 2);
    ext(ALL, 1, 1, 1, 10'h001);
    ext(ALL, 1, 3, 3, 10'h023);
`else
    issue(2'b10, 0, 0, 10'h003, 0, 0, 0, 0, 0);
    chk("flush_num", num, 3);
    ext(ALL, 1, 1, 1, 10'h001);
    ext(ALL, 1, 2, 2, 10'h013);
`endif
    repeat (3) @(negedge clk);
    chk("no_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
